// File: rtl/alu_ctrl_pkg.sv
// Shared opcode constants, FSM state encoding and opcode legality helper for alu_arbiter.
package alu_ctrl_pkg;

  localparam logic [2:0] OP_NOT        = 3'b000;
  localparam logic [2:0] OP_AND        = 3'b001;
  localparam logic [2:0] OP_OR         = 3'b010;
  localparam logic [2:0] OP_XOR        = 3'b011;
  localparam logic [2:0] OP_ADD        = 3'b100;
  localparam logic [2:0] OP_LAST_LEGAL = OP_ADD;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic op_is_legal(input logic [2:0] op);
    return op <= OP_LAST_LEGAL;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the requester that wins a tie and
// moves past the current winner when advance_i is pulsed.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o
);

  logic ptr_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

  // Served requester 0 -> requester 1 gets priority next, and vice versa.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst)            ptr_q <= 1'b0;
    else if (advance_i) ptr_q <= gnt_o[0];
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters (IDLE->EXEC->RESP).
// Optional ALU_ILLEGAL_OP_ERR_EN adds rsp_err_o and blocks illegal opcodes from the ALU.
module alu_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int OPW   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid_i,
  output logic [1:0]           req_ready_o,
  input  logic [2*WIDTH-1:0]   req_a_i,
  input  logic [2*WIDTH-1:0]   req_b_i,
  input  logic [2*OPW-1:0]     req_op_i,
  output logic [1:0]           rsp_valid_o,
  input  logic [1:0]           rsp_ready_i,
  output logic [WIDTH-1:0]     rsp_c_o,
  output logic                 rsp_co_o,
`ifdef ALU_ILLEGAL_OP_ERR_EN
  output logic                 rsp_err_o,
`endif
  output logic [WIDTH-1:0]     alu_a_o,
  output logic [WIDTH-1:0]     alu_b_o,
  output logic [OPW-1:0]       alu_op_o,
  input  logic [WIDTH-1:0]     alu_c_i,
  input  logic                 alu_co_i
);

  state_t           state_q, state_d;
  logic             gnt_idx_q;
  logic [WIDTH-1:0] a_q, b_q, rsp_c_q;
  logic [OPW-1:0]   op_q;
  logic             rsp_co_q;
  logic [1:0]       arb_req, arb_gnt;
  logic             advance;
  logic             win_idx;
  logic [WIDTH-1:0] win_a, win_b;
  logic [OPW-1:0]   win_op;

  // While responding, the arbiter only sees the served requester so advance moves past it.
  always_comb begin
    arb_req = req_valid_i;
    if (state_q == RESP) arb_req = gnt_idx_q ? 2'b10 : 2'b01;
  end

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .rst       (rst),
    .req_i     (arb_req),
    .advance_i (advance),
    .gnt_o     (arb_gnt)
  );

  assign win_idx = arb_gnt[1];
  assign win_a   = win_idx ? req_a_i[2*WIDTH-1:WIDTH] : req_a_i[WIDTH-1:0];
  assign win_b   = win_idx ? req_b_i[2*WIDTH-1:WIDTH] : req_b_i[WIDTH-1:0];
  assign win_op  = win_idx ? req_op_i[2*OPW-1:OPW]    : req_op_i[OPW-1:0];

  always_comb begin
    state_d     = state_q;
    req_ready_o = 2'b00;
    rsp_valid_o = 2'b00;
    advance     = 1'b0;
    unique case (state_q)
      IDLE: if (|req_valid_i) begin
        req_ready_o = arb_gnt;
        state_d     = EXEC;
      end
      EXEC: state_d = RESP;
      RESP: begin
        rsp_valid_o[gnt_idx_q] = 1'b1;
        if (rsp_ready_i[gnt_idx_q]) begin
          advance = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ALU_ILLEGAL_OP_ERR_EN
  logic illegal_q, rsp_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_q <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      if (state_q == IDLE && |req_valid_i) illegal_q <= !op_is_legal(win_op);
      if (state_q == EXEC)                 rsp_err_q <= illegal_q;
    end
  end

  assign rsp_err_o = rsp_err_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: all datapath registers are reset because alu_* and rsp_* must never show X.
    if (rst) begin
      state_q   <= IDLE;
      gnt_idx_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      rsp_c_q   <= '0;
      rsp_co_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && |req_valid_i) begin
        gnt_idx_q <= win_idx;
        a_q       <= win_a;
        b_q       <= win_b;
`ifdef ALU_ILLEGAL_OP_ERR_EN
        op_q      <= op_is_legal(win_op) ? win_op : OP_NOT;
`else
        op_q      <= win_op;
`endif
      end
      if (state_q == EXEC) begin
`ifdef ALU_ILLEGAL_OP_ERR_EN
        // The substituted NOT still produces ~a, so illegal ops must be zeroed here.
        rsp_c_q  <= illegal_q ? '0 : alu_c_i;
        rsp_co_q <= illegal_q ? 1'b0 : alu_co_i;
`else
        rsp_c_q  <= alu_c_i;
        rsp_co_q <= alu_co_i;
`endif
      end
    end
  end

  assign alu_a_o  = a_q;
  assign alu_b_o  = b_q;
  assign alu_op_o = op_q;
  assign rsp_c_o  = rsp_c_q;
  assign rsp_co_o = rsp_co_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural 4-bit ALU; directed vectors.
module tb_alu_arbiter;
  import alu_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [7:0] req_a, req_b;
  logic [5:0] req_op;
  logic [3:0] rsp_c, alu_a, alu_b, alu_c;
  logic       rsp_co, alu_co;
  logic [2:0] alu_op;
`ifdef ALU_ILLEGAL_OP_ERR_EN
  logic       rsp_err;
`endif

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(4), .OPW(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .req_op_i    (req_op),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_c_o     (rsp_c),
    .rsp_co_o    (rsp_co),
`ifdef ALU_ILLEGAL_OP_ERR_EN
    .rsp_err_o   (rsp_err),
`endif
    .alu_a_o     (alu_a),
    .alu_b_o     (alu_b),
    .alu_op_o    (alu_op),
    .alu_c_i     (alu_c),
    .alu_co_i    (alu_co)
  );

  // External combinational ALU
  always_comb begin
    {alu_co, alu_c} = 5'd0;
    case (alu_op)
      3'b000: alu_c = ~alu_a;
      3'b001: alu_c = alu_a & alu_b;
      3'b010: alu_c = alu_a | alu_b;
      3'b011: alu_c = alu_a ^ alu_b;
      3'b100: {alu_co, alu_c} = {1'b0, alu_a} + {1'b0, alu_b};
      default: {alu_co, alu_c} = 5'd0;
    endcase
  end

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [3:0] c;
    logic       co;
    logic       err;
  } job_t;

  typedef struct {
    int   idx;
    job_t j;
    int   acc_cyc;
  } exp_t;

  job_t jobs0[$], jobs1[$];
  exp_t sb[$];
  int   served[$];
  int   checks = 0, failures = 0;
  int   cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic add(input int idx, input logic [3:0] a, input logic [3:0] b,
                     input logic [2:0] op, input logic [3:0] c, input logic co, input logic err);
    job_t j;
    j.a = a; j.b = b; j.op = op; j.c = c; j.co = co; j.err = err;
    if (idx == 0) jobs0.push_back(j);
    else          jobs1.push_back(j);
  endtask

  // Driver: presents the head job of each requester, pushes the expectation on accept.
  initial begin
    logic [1:0] acc;
    int         acc_cyc;
    exp_t       e;
    req_valid = 2'b00; req_a = '0; req_b = '0; req_op = '0;
    forever begin
      @(negedge clk);
      acc     = req_valid & req_ready;
      acc_cyc = cyc;
      @(posedge clk);
      #1;
      if (acc[0] && jobs0.size() != 0) begin
        e.idx = 0; e.j = jobs0[0]; e.acc_cyc = acc_cyc;
        sb.push_back(e);
        void'(jobs0.pop_front());
      end
      if (acc[1] && jobs1.size() != 0) begin
        e.idx = 1; e.j = jobs1[0]; e.acc_cyc = acc_cyc;
        sb.push_back(e);
        void'(jobs1.pop_front());
      end
      req_valid[0] = jobs0.size() != 0;
      if (jobs0.size() != 0) begin
        req_a[3:0] = jobs0[0].a; req_b[3:0] = jobs0[0].b; req_op[2:0] = jobs0[0].op;
      end
      req_valid[1] = jobs1.size() != 0;
      if (jobs1.size() != 0) begin
        req_a[7:4] = jobs1[0].a; req_b[7:4] = jobs1[0].b; req_op[5:3] = jobs1[0].op;
      end
    end
  end

  // Monitor: compares every presented response against the scoreboard head.
  initial begin
    exp_t e;
    int   idx;
    bit   seen_first = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid != 2'b00) begin
        check("rsp_valid_onehot", $onehot(rsp_valid), 1);
        check("no_req_ready_in_resp", req_ready, 2'b00);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp: got rsp_valid=%b expected none", rsp_valid);
        end else begin
          e   = sb[0];
          idx = rsp_valid[1] ? 1 : 0;
          check("rsp_idx", idx, e.idx);
          check("rsp_c", rsp_c, e.j.c);
          check("rsp_co", rsp_co, e.j.co);
`ifdef ALU_ILLEGAL_OP_ERR_EN
          check("rsp_err", rsp_err, e.j.err);
`endif
          if (!seen_first) check("latency", cyc - e.acc_cyc, 2);
          seen_first = 1'b1;
          if (rsp_ready[idx]) begin
            served.push_back(idx);
            void'(sb.pop_front());
            seen_first = 1'b0;
          end
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 2'b00);
    check({tag, "_rsp_valid"}, rsp_valid, 2'b00);
    check({tag, "_rsp_c"}, rsp_c, 4'h0);
    check({tag, "_rsp_co"}, rsp_co, 1'b0);
    check({tag, "_alu_a"}, alu_a, 4'h0);
    check({tag, "_alu_b"}, alu_b, 4'h0);
    check({tag, "_alu_op"}, alu_op, 3'b000);
`ifdef ALU_ILLEGAL_OP_ERR_EN
    check({tag, "_rsp_err"}, rsp_err, 1'b0);
`endif
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && jobs0.size() == 0 && jobs1.size() == 0 &&
          rsp_valid == 2'b00 && req_valid == 2'b00) return;
    end
    checks++;
    failures++;
    $display("FAIL %s_timeout: got busy after 200 cycles expected idle", tag);
  endtask

  task automatic wait_ready(input int idx, input string tag);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready[idx]) return;
    end
    checks++;
    failures++;
    $display("FAIL %s_timeout: got no req_ready[%0d] expected accept", tag, idx);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sb.delete(); jobs0.delete(); jobs1.delete(); served.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    rsp_ready = 2'b00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Single ADD with carry
    sync();
    rsp_ready = 2'b11;
    add(0, 4'hF, 4'h1, OP_ADD, 4'h0, 1'b1, 1'b0);
    wait_idle("t1");

    // Contention from reset: requester 0 first
    do_reset();
    sync();
    add(0, 4'hA, 4'h5, OP_XOR, 4'hF, 1'b0, 1'b0);
    add(1, 4'hC, 4'hA, OP_AND, 4'h8, 1'b0, 1'b0);
    wait_idle("t2");
    check("t2_count", served.size(), 2);
    if (served.size() == 2) begin
      check("t2_first", served[0], 0);
      check("t2_second", served[1], 1);
    end

    // Back-pressure: response held for 5 cycles, peer waits
    sync();
    rsp_ready = 2'b00;
    add(0, 4'h3, 4'h0, OP_NOT, 4'hC, 1'b0, 1'b0);
    wait_ready(0, "t3_accept");
    sync();
    add(1, 4'hF, 4'hF, OP_AND, 4'hF, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    #1 rsp_ready = 2'b11;
    @(negedge clk);
    @(negedge clk);
    check("t3_idle_after_rsp", req_ready, 2'b10);
    wait_idle("t3");

    // Fairness: both continuously valid for 6 ops
    sync();
    served.delete();
    add(0, 4'h1, 4'h2, OP_OR,  4'h3, 1'b0, 1'b0);
    add(0, 4'h7, 4'h8, OP_ADD, 4'hF, 1'b0, 1'b0);
    add(0, 4'hF, 4'hF, OP_XOR, 4'h0, 1'b0, 1'b0);
    add(1, 4'h9, 4'h9, OP_ADD, 4'h2, 1'b1, 1'b0);
    add(1, 4'hF, 4'h3, OP_AND, 4'h3, 1'b0, 1'b0);
    add(1, 4'h0, 4'h0, OP_NOT, 4'hF, 1'b0, 1'b0);
    wait_idle("t4");
    check("t4_count", served.size(), 6);
    for (int k = 0; k < 6; k++)
      if (k < served.size()) check($sformatf("t4_grant%0d", k), served[k], k % 2);

    // Reset while in EXEC aborts the operation
    sync();
    add(1, 4'h5, 4'h6, OP_OR, 4'h7, 1'b0, 1'b0);
    wait_ready(1, "t5_accept");
    @(negedge clk);
    check("t5_exec_alu_a", alu_a, 4'h5);
    check("t5_exec_alu_op", alu_op, OP_OR);
    rst = 1'b1;
    #1;
    check_reset_outputs("t5_reset");
    sb.delete(); jobs0.delete(); jobs1.delete(); served.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_no_rsp", rsp_valid, 2'b00);
    sync();
    add(0, 4'h2, 4'h3, OP_ADD, 4'h5, 1'b0, 1'b0);
    add(1, 4'h4, 4'h4, OP_ADD, 4'h8, 1'b0, 1'b0);
    wait_idle("t5");
    check("t5_count", served.size(), 2);
    if (served.size() == 2) check("t5_first_after_reset", served[0], 0);

    // Illegal opcode 110
    sync();
    add(0, 4'h7, 4'h7, 3'b110, 4'h0, 1'b0, 1'b1);
    wait_ready(0, "t6_accept");
    @(negedge clk);
`ifdef ALU_ILLEGAL_OP_ERR_EN
    check("t6_alu_op_forced", alu_op, 3'b000);
`else
    check("t6_alu_op_pass", alu_op, 3'b110);
`endif
    wait_idle("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "global timeout");
  end

endmodule
